// File: rtl/frame_transmitter_pkg.sv
// Shared definitions for the GMII frame transmitter.
// Holds the FSM state encodings, the preamble/SFD byte values and the
// default values for the maximum frame length and inter-frame gap.
package frame_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_IFG      = 3'd4,
        ST_DROP     = 3'd5
    } tx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // Preamble counter runs 0..6, giving seven preamble bytes.
    localparam logic [2:0] PREAMBLE_LAST = 3'd6;

    localparam int DEF_MAX_LEN = 1522;
    localparam int DEF_IFG     = 12;

    // True for the states in which the GMII transmit enable is driven high.
    function automatic logic is_tx_state(input tx_state_e st);
        return (st == ST_PREAMBLE) || (st == ST_SFD) || (st == ST_DATA);
    endfunction

endpackage

// File: rtl/frame_transmitter.sv
// GMII frame transmitter.
// Pops a frame length from a show-ahead length FIFO, then sends
// 7 preamble bytes, one SFD byte and N data bytes read from packet memory,
// followed by an inter-frame gap. Oversized lengths are dropped by reading
// (and discarding) their bytes so the memory pointer stays aligned; a zero
// length is popped and flagged without any reads.
//
// Ports:
//   iclk       clock
//   i_rst      synchronous active-high reset
//   i_len_val  length FIFO not empty (i_len valid in the same cycle)
//   i_len      byte count of the next frame
//   o_len_rd   one-cycle pop of the length FIFO (combinational)
//   o_rd_en    packet memory read request (combinational)
//   i_rd_data  memory byte, valid one cycle after o_rd_en
//   i_pause    blocks the start of a new frame only
//   o_tx_en    GMII transmit enable
//   o_tx_er    GMII transmit error, constant 0
//   o_txd      GMII transmit data
//   o_state    current FSM state
//   o_len_err  one-cycle pulse when a frame is dropped
module frame_transmitter
    import frame_transmitter_pkg::*;
#(
    parameter int pMAX_LEN = DEF_MAX_LEN,
    parameter int pIFG     = DEF_IFG
) (
    input  logic        iclk,
    input  logic        i_rst,
    input  logic        i_len_val,
    input  logic [10:0] i_len,
    output logic        o_len_rd,
    output logic        o_rd_en,
    input  logic [7:0]  i_rd_data,
    input  logic        i_pause,
    output logic        o_tx_en,
    output logic        o_tx_er,
    output logic [7:0]  o_txd,
    output logic [2:0]  o_state,
    output logic        o_len_err
);

    localparam logic [10:0] MAX_LEN_C  = 11'(pMAX_LEN);
    localparam logic [3:0]  IFG_LAST_C = 4'(pIFG - 1);

    tx_state_e   state_r;
    tx_state_e   next_state_s;
    logic [10:0] byte_cnt_r;
    logic [10:0] byte_cnt_s;
    logic [2:0]  pre_cnt_r;
    logic [2:0]  pre_cnt_s;
    logic [3:0]  ifg_cnt_r;
    logic [3:0]  ifg_cnt_s;
    logic        pop_s;
    logic        rd_s;
    logic        bad_len_s;
    logic [7:0]  txd_s;
    logic        tx_en_r;
    logic        len_err_r;
    logic        data_sel_r;
    logic [7:0]  txd_r;

    // Next-state, counter update and read/pop decode.
    always_comb begin
        next_state_s = state_r;
        byte_cnt_s   = byte_cnt_r;
        pre_cnt_s    = pre_cnt_r;
        ifg_cnt_s    = ifg_cnt_r;
        pop_s        = 1'b0;
        rd_s         = 1'b0;
        bad_len_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_len_val && !i_pause) begin
                    pop_s     = 1'b1;
                    pre_cnt_s = 3'd0;
                    if (i_len == 11'd0) begin
                        bad_len_s    = 1'b1;
                        byte_cnt_s   = 11'd0;
                        next_state_s = ST_IDLE;
                    end else if (i_len > MAX_LEN_C) begin
                        bad_len_s    = 1'b1;
                        byte_cnt_s   = i_len;
                        next_state_s = ST_DROP;
                    end else begin
                        byte_cnt_s   = i_len;
                        next_state_s = ST_PREAMBLE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (pre_cnt_r == PREAMBLE_LAST) begin
                    pre_cnt_s    = 3'd0;
                    next_state_s = ST_SFD;
                end else begin
                    pre_cnt_s = pre_cnt_r + 3'd1;
                end
            end
            ST_SFD: begin
                // Byte 1 is fetched here so it is on i_rd_data in DATA cycle 1.
                if (byte_cnt_r != 11'd0) begin
                    rd_s       = 1'b1;
                    byte_cnt_s = byte_cnt_r - 11'd1;
                end else begin
                    byte_cnt_s = 11'd0;
                end
                next_state_s = ST_DATA;
            end
            ST_DATA: begin
                // A zero count means the byte on the bus now is the last one.
                if (byte_cnt_r != 11'd0) begin
                    rd_s       = 1'b1;
                    byte_cnt_s = byte_cnt_r - 11'd1;
                end else begin
                    ifg_cnt_s    = 4'd0;
                    next_state_s = ST_IFG;
                end
            end
            ST_IFG: begin
                if (ifg_cnt_r == IFG_LAST_C) begin
                    ifg_cnt_s    = 4'd0;
                    next_state_s = ST_IDLE;
                end else begin
                    ifg_cnt_s = ifg_cnt_r + 4'd1;
                end
            end
            ST_DROP: begin
                // Discard reads keep the memory pointer in step with the FIFO.
                if (byte_cnt_r != 11'd0) begin
                    rd_s       = 1'b1;
                    byte_cnt_s = byte_cnt_r - 11'd1;
                end else begin
                    byte_cnt_s = 11'd0;
                end
                if (byte_cnt_r <= 11'd1) begin
                    ifg_cnt_s    = 4'd0;
                    next_state_s = ST_IFG;
                end else begin
                    next_state_s = ST_DROP;
                end
            end
            default: begin
                byte_cnt_s   = 11'd0;
                pre_cnt_s    = 3'd0;
                ifg_cnt_s    = 4'd0;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Transmit byte to present in the coming cycle, decoded from the next state.
    always_comb begin
        txd_s = 8'h00;
        case (next_state_s)
            ST_PREAMBLE: txd_s = PREAMBLE_BYTE;
            ST_SFD:      txd_s = SFD_BYTE;
            default:     txd_s = 8'h00;
        endcase
    end

    // State, counters and registered GMII outputs.
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= 11'd0;
            pre_cnt_r  <= 3'd0;
            ifg_cnt_r  <= 4'd0;
            tx_en_r    <= 1'b0;
            len_err_r  <= 1'b0;
            data_sel_r <= 1'b0;
            txd_r      <= 8'h00;
        end else begin
            state_r    <= next_state_s;
            byte_cnt_r <= byte_cnt_s;
            pre_cnt_r  <= pre_cnt_s;
            ifg_cnt_r  <= ifg_cnt_s;
            tx_en_r    <= is_tx_state(next_state_s);
            len_err_r  <= bad_len_s;
            data_sel_r <= (next_state_s == ST_DATA);
            txd_r      <= txd_s;
        end
    end

    // The memory already returns its byte from a register one cycle after
    // the request, so data bytes are steered onto o_txd without a further
    // pipeline stage; that keeps SFD and DATA contiguous.
    assign o_txd     = data_sel_r ? i_rd_data : txd_r;
    assign o_tx_en   = tx_en_r;
    assign o_tx_er   = 1'b0;
    assign o_state   = state_r;
    assign o_len_err = len_err_r;
    assign o_len_rd  = pop_s && !i_rst;
    assign o_rd_en   = rd_s && !i_rst;

endmodule

// File: tb/tb_frame_transmitter.sv
// Directed self-checking bench for frame_transmitter.
// A small length FIFO and a packet memory whose byte at address a is a[7:0]
// are modelled here; expected GMII streams are rebuilt from the queued lengths.
module tb_frame_transmitter;

    logic        iclk = 1'b0;
    logic        i_rst;
    logic        i_len_val;
    logic [10:0] i_len;
    logic        o_len_rd;
    logic        o_rd_en;
    logic [7:0]  i_rd_data;
    logic        i_pause;
    logic        o_tx_en;
    logic        o_tx_er;
    logic [7:0]  o_txd;
    logic [2:0]  o_state;
    logic        o_len_err;

    int checks = 0;
    int fails  = 0;

    logic [10:0] len_q [0:7];
    int q_head = 0;
    int q_tail = 0;
    int mem_addr = 0;
    int rd_count = 0;
    int pop_count = 0;
    int err_count = 0;
    int exp_base = 0;

    always #5 iclk = ~iclk;

    frame_transmitter dut (
        .iclk      (iclk),
        .i_rst     (i_rst),
        .i_len_val (i_len_val),
        .i_len     (i_len),
        .o_len_rd  (o_len_rd),
        .o_rd_en   (o_rd_en),
        .i_rd_data (i_rd_data),
        .i_pause   (i_pause),
        .o_tx_en   (o_tx_en),
        .o_tx_er   (o_tx_er),
        .o_txd     (o_txd),
        .o_state   (o_state),
        .o_len_err (o_len_err)
    );

    assign i_len_val = (q_head != q_tail);
    assign i_len     = len_q[q_head[2:0]];

    // FIFO pop, memory model and event counters.
    always @(posedge iclk) begin
        if (o_len_rd) q_head <= q_head + 1;
        if (i_rst) mem_addr <= 0;
        else if (o_rd_en) mem_addr <= mem_addr + 1;
        i_rd_data <= o_rd_en ? 8'(mem_addr) : 8'hEE;
        rd_count  <= rd_count + (o_rd_en ? 1 : 0);
        pop_count <= pop_count + (o_len_rd ? 1 : 0);
        err_count <= err_count + (o_len_err ? 1 : 0);
    end

    task automatic push_len(input logic [10:0] n);
        len_q[q_tail[2:0]] = n;
        q_tail = q_tail + 1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_pause = 1'b0;
        repeat (3) @(negedge iclk);
        checks++;
        if (o_state !== 3'd0 || o_tx_en !== 1'b0 || o_tx_er !== 1'b0 || o_txd !== 8'h00 || o_len_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got st=%0d en=%b er=%b txd=%h err=%b, want 0 0 0 00 0",
                     o_state, o_tx_en, o_tx_er, o_txd, o_len_err);
        end
        push_len(11'd64);
        @(negedge iclk);
        checks++;
        if (o_len_rd !== 1'b0 || o_rd_en !== 1'b0 || o_state !== 3'd0) begin
            fails++;
            $display("FAIL reset_hold: got len_rd=%b rd_en=%b st=%0d, want 0 0 0", o_len_rd, o_rd_en, o_state);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_single_frame();
        int rd0, pop0, t;
        logic [7:0] exp_txd;
        logic [2:0] exp_st;
        logic exp_rd;
        rd0 = rd_count;
        pop0 = pop_count;
        t = 0;
        while (o_tx_en !== 1'b1 && t < 50) begin @(negedge iclk); t++; end
        checks++;
        if (t > 1) begin fails++; $display("FAIL single_start: got preamble after %0d cycles, want 1", t); end
        for (int k = 0; k < 72; k++) begin
            exp_txd = (k < 7) ? 8'h55 : ((k == 7) ? 8'hD5 : 8'(exp_base + k - 8));
            exp_st  = (k < 7) ? 3'd1 : ((k == 7) ? 3'd2 : 3'd3);
            exp_rd  = (k >= 7) && (k < 71);
            checks++;
            if (o_tx_en !== 1'b1 || o_txd !== exp_txd || o_state !== exp_st || o_rd_en !== exp_rd) begin
                fails++;
                $display("FAIL single k=%0d: got en=%b txd=%h st=%0d rd=%b, want en=1 txd=%h st=%0d rd=%b",
                         k, o_tx_en, o_txd, o_state, o_rd_en, exp_txd, exp_st, exp_rd);
            end
            @(negedge iclk);
        end
        checks++;
        if (o_tx_en !== 1'b0 || o_state !== 3'd4 || o_txd !== 8'h00) begin
            fails++;
            $display("FAIL single_end: got en=%b st=%0d txd=%h, want 0 4 00", o_tx_en, o_state, o_txd);
        end
        checks++;
        if (rd_count - rd0 != 64 || pop_count - pop0 != 1) begin
            fails++;
            $display("FAIL single_counts: got reads=%0d pops=%0d, want 64 1", rd_count - rd0, pop_count - pop0);
        end
        exp_base += 64;
    endtask

    task automatic test_back_to_back();
        int t, gap, n;
        logic [7:0] exp_txd;
        push_len(11'd60);
        push_len(11'd100);
        t = 0;
        while (o_tx_en !== 1'b1 && t < 50) begin @(negedge iclk); t++; end
        for (int f = 0; f < 2; f++) begin
            n = (f == 0) ? 60 : 100;
            for (int k = 0; k < 8 + n; k++) begin
                exp_txd = (k < 7) ? 8'h55 : ((k == 7) ? 8'hD5 : 8'(exp_base + k - 8));
                checks++;
                if (o_tx_en !== 1'b1 || o_txd !== exp_txd) begin
                    fails++;
                    $display("FAIL b2b f=%0d k=%0d: got en=%b txd=%h, want en=1 txd=%h", f, k, o_tx_en, o_txd, exp_txd);
                end
                @(negedge iclk);
            end
            exp_base += n;
            if (f == 0) begin
                gap = 0;
                while (o_tx_en !== 1'b1 && gap < 40) begin @(negedge iclk); gap++; end
                checks++;
                if (gap != 13) begin fails++; $display("FAIL b2b_gap: got %0d idle cycles, want 13", gap); end
            end
        end
    endtask

    task automatic test_drop();
        int rd0, err0, pop0, t;
        logic [7:0] exp_txd;
        rd0 = rd_count;
        err0 = err_count;
        pop0 = pop_count;
        push_len(11'd1600);
        push_len(11'd64);
        t = 0;
        while (o_tx_en !== 1'b1 && t < 2500) begin
            if (o_len_err === 1'b1) begin
                checks++;
                if (o_state !== 3'd5) begin fails++; $display("FAIL drop_state: got %0d at error pulse, want 5", o_state); end
            end
            @(negedge iclk);
            t++;
        end
        checks++;
        if (o_tx_en !== 1'b1) begin fails++; $display("FAIL drop_timeout: got no frame after %0d cycles, want one", t); end
        checks++;
        if (err_count - err0 != 1) begin fails++; $display("FAIL drop_err: got %0d pulses, want 1", err_count - err0); end
        checks++;
        if (rd_count - rd0 != 1600) begin fails++; $display("FAIL drop_reads: got %0d, want 1600", rd_count - rd0); end
        exp_base += 1600;
        for (int k = 0; k < 72; k++) begin
            exp_txd = (k < 7) ? 8'h55 : ((k == 7) ? 8'hD5 : 8'(exp_base + k - 8));
            checks++;
            if (o_tx_en !== 1'b1 || o_txd !== exp_txd) begin
                fails++;
                $display("FAIL drop_next k=%0d: got en=%b txd=%h, want en=1 txd=%h", k, o_tx_en, o_txd, exp_txd);
            end
            @(negedge iclk);
        end
        exp_base += 64;
        checks++;
        if (pop_count - pop0 != 2) begin fails++; $display("FAIL drop_pops: got %0d, want 2", pop_count - pop0); end
    endtask

    task automatic test_zero_len();
        int rd0, err0, pop0, bad;
        rd0 = rd_count;
        err0 = err_count;
        pop0 = pop_count;
        bad = 0;
        push_len(11'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge iclk);
            if (o_tx_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL zero_txen: got %0d enabled cycles, want 0", bad); end
        checks++;
        if (err_count - err0 != 1 || rd_count - rd0 != 0 || pop_count - pop0 != 1) begin
            fails++;
            $display("FAIL zero_counts: got err=%0d reads=%0d pops=%0d, want 1 0 1",
                     err_count - err0, rd_count - rd0, pop_count - pop0);
        end
        checks++;
        if (o_state !== 3'd0) begin fails++; $display("FAIL zero_state: got %0d, want 0", o_state); end
    endtask

    task automatic test_pause();
        logic [7:0] exp_txd;
        i_pause = 1'b1;
        push_len(11'd64);
        for (int i = 0; i < 5; i++) begin
            @(negedge iclk);
            checks++;
            if (o_len_rd !== 1'b0 || o_tx_en !== 1'b0) begin
                fails++;
                $display("FAIL pause_hold i=%0d: got len_rd=%b en=%b, want 0 0", i, o_len_rd, o_tx_en);
            end
        end
        i_pause = 1'b0;
        #1;
        checks++;
        if (o_len_rd !== 1'b1) begin fails++; $display("FAIL pause_release: got len_rd=%b, want 1", o_len_rd); end
        @(negedge iclk);
        for (int k = 0; k < 72; k++) begin
            exp_txd = (k < 7) ? 8'h55 : ((k == 7) ? 8'hD5 : 8'(exp_base + k - 8));
            checks++;
            if (o_tx_en !== 1'b1 || o_txd !== exp_txd) begin
                fails++;
                $display("FAIL pause_frame k=%0d: got en=%b txd=%h, want en=1 txd=%h", k, o_tx_en, o_txd, exp_txd);
            end
            if (k == 17) i_pause = 1'b1;
            @(negedge iclk);
        end
        exp_base += 64;
        i_pause = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t;
        logic [7:0] exp_txd;
        push_len(11'd64);
        t = 0;
        while (o_tx_en !== 1'b1 && t < 50) begin @(negedge iclk); t++; end
        for (int k = 0; k < 28; k++) begin
            exp_txd = (k < 7) ? 8'h55 : ((k == 7) ? 8'hD5 : 8'(exp_base + k - 8));
            checks++;
            if (o_tx_en !== 1'b1 || o_txd !== exp_txd) begin
                fails++;
                $display("FAIL rstmid_pre k=%0d: got en=%b txd=%h, want en=1 txd=%h", k, o_tx_en, o_txd, exp_txd);
            end
            if (k == 27) i_rst = 1'b1;
            else @(negedge iclk);
        end
        @(negedge iclk);
        checks++;
        if (o_tx_en !== 1'b0 || o_state !== 3'd0 || o_txd !== 8'h00) begin
            fails++;
            $display("FAIL rstmid_cut: got en=%b st=%0d txd=%h, want 0 0 00", o_tx_en, o_state, o_txd);
        end
        i_rst = 1'b0;
        exp_base = 0;
        push_len(11'd64);
        t = 0;
        while (o_tx_en !== 1'b1 && t < 20) begin @(negedge iclk); t++; end
        checks++;
        if (t < 1 || t > 2) begin fails++; $display("FAIL rstmid_restart: got preamble after %0d cycles, want 1..2", t); end
        for (int k = 0; k < 72; k++) begin
            exp_txd = (k < 7) ? 8'h55 : ((k == 7) ? 8'hD5 : 8'(exp_base + k - 8));
            checks++;
            if (o_tx_en !== 1'b1 || o_txd !== exp_txd) begin
                fails++;
                $display("FAIL rstmid_post k=%0d: got en=%b txd=%h, want en=1 txd=%h", k, o_tx_en, o_txd, exp_txd);
            end
            @(negedge iclk);
        end
        checks++;
        if (o_tx_en !== 1'b0) begin fails++; $display("FAIL rstmid_end: got en=%b, want 0", o_tx_en); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_drop();
        test_zero_len();
        test_pause();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, want completion within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
